ysyx_23060124_ifu_fetch: RTL and testbench
==========================================

Name: ysyx_23060124_ifu_fetch

Overview:
Multi-cycle instruction fetch stage that replaces the combinational fetch path ahead of the decoder.
- Holds the architectural PC.
- Issues one read per instruction on an AXI4-Lite-style read channel (AR/R only).
- Presents the fetched word to the decode stage with a valid/ready handshake.
- Waits for the PC-update unit to supply the next PC before starting the next fetch.
- At most one fetch is outstanding at any time.

Parameters:
ISA_WIDTH, 32, instruction/address/data width
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles in WAIT before a fetch is declared failed (8-bit counter)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
i_pc_update  in  1  PC-update unit strobe: i_pc_next is valid this cycle
i_pc_next  in  ISA_WIDTH  next PC from the PC-update unit
o_araddr  out  ISA_WIDTH  read address
o_arvalid  out  1  read address valid
i_arready  in  1  memory accepts address
i_rdata  in  ISA_WIDTH  read data
i_rresp  in  2  read response; 2'b00 = OKAY, anything else = error
i_rvalid  in  1  read data valid
o_rready  out  1  fetch ready for read data
o_valid  out  1  instruction valid to decode
i_ready  in  1  decode accepts instruction
o_ins  out  ISA_WIDTH  instruction word
o_pc  out  ISA_WIDTH  PC of o_ins
o_fetch_err  out  1  qualifies o_ins: bus error or timeout on this fetch
o_fetch_cnt  out  32  count of instructions handed to decode (wraps)

Behaviour:
Reset: synchronous, active-high; rst wins over every other input in the same cycle.
- While rst=1: state=REQ, pc=RESET_PC, o_arvalid=0, o_rready=0, o_valid=0, o_ins=0, o_pc=0, o_fetch_err=0, o_fetch_cnt=0, timeout counter=0.
- First cycle after rst falls: o_arvalid=1, o_araddr=RESET_PC.
- rst mid-fetch abandons the fetch; the memory side must itself be reset with the same rst.

States:
- REQ: o_arvalid=1, o_araddr=pc.
  - i_arready=1 -> WAIT, timeout counter cleared.
  - o_araddr stays stable and o_arvalid stays high until accepted.
- WAIT: o_rready=1; timeout counter increments each cycle.
  - i_rvalid=1 -> latch o_ins=i_rdata, o_pc=pc, o_fetch_err=(i_rresp!=0); go to HOLD.
  - Counter reaches TIMEOUT without i_rvalid -> o_ins=32'h0000_0013 (nop), o_fetch_err=1; go to HOLD.
  - A late i_rvalid arriving after the timeout is ignored.
- HOLD: o_valid=1; o_ins, o_pc and o_fetch_err stay stable.
  - i_ready=1 -> o_fetch_cnt+=1, o_valid drops next cycle; go to WAIT_PC.
- WAIT_PC: all handshake outputs low.
  - i_pc_update=1 -> pc<=i_pc_next; go to REQ.
  - Next fetch starts the cycle after the update, i.e. o_arvalid rises 1 cycle after i_pc_update.

Latency: with zero-wait memory and decode, REQ->WAIT->HOLD->WAIT_PC is 3 cycles minimum; the instruction becomes visible 2 cycles after o_arvalid first rises.

Edge rules:
- i_pc_update in REQ/WAIT/HOLD is ignored: protocol violation, flagged by an assertion.
- i_pc_update in the same cycle as the HOLD handshake is ignored; it must arrive in WAIT_PC.
- i_rvalid outside WAIT is ignored.
- pc[1:0]!=0 is not checked here; the address is issued as-is.
- o_fetch_cnt wraps from 32'hFFFF_FFFF to 0.

Decomposition:
- Shared defines file: ISA width define, RESET_PC constant, nop encoding 32'h0000_0013, RRESP_OKAY=2'b00, 2-bit state encoding (REQ=0, WAIT=1, HOLD=2, WAIT_PC=3).
- One natural sub-module: ysyx_23060124_ifu_timeout, the 8-bit clear/enable counter with a terminal-count output.
- The fetch FSM, PC register and output latch stay in the top of this block.

Test Plan:
- Reset then zero-wait memory returning 32'h0010_0073, i_ready=1 -> o_araddr=0x8000_0000 in cycle 1; o_valid=1 with o_ins=32'h0010_0073, o_pc=0x8000_0000, o_fetch_err=0; o_fetch_cnt=1.
- i_arready held low 3 cycles -> o_arvalid and o_araddr stay stable for all 3 cycles; exactly one address handshake occurs.
- i_ready low 5 cycles in HOLD -> o_ins/o_pc stable throughout; i_pc_update pulse with 0x8000_0004 during HOLD is ignored; a later pulse in WAIT_PC fetches 0x8000_0004.
- i_rresp=2'b10 with i_rdata=32'hDEAD_BEEF -> o_ins=32'hDEAD_BEEF, o_fetch_err=1.
- No i_rvalid for 255 cycles -> o_ins=32'h0000_0013, o_fetch_err=1; a late i_rvalid at cycle 260 is ignored.
- rst asserted in WAIT, then deasserted -> outputs zero during reset; next fetch at 0x8000_0000 with o_fetch_cnt=0.

Source files
------------

// File: rtl/ysyx_23060124_ifu_fetch_pkg.sv
// Shared constants and state encoding for the multi-cycle instruction fetch stage.
package ysyx_23060124_ifu_fetch_pkg;

  localparam int          IFU_ISA_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC  = 32'h8000_0000;
  localparam int          IFU_TIMEOUT   = 255;
  localparam int          TIMEOUT_W     = 8;
  localparam logic [31:0] NOP_INS       = 32'h0000_0013;
  localparam logic [1:0]  RRESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_WAIT_PC = 2'd3
  } fetch_state_e;

  function automatic logic is_bus_error(input logic [1:0] resp);
    return resp != RRESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_23060124_ifu_timeout.sv
// Clear/enable cycle counter that flags the last permitted cycle of a read wait.
module ysyx_23060124_ifu_timeout
  import ysyx_23060124_ifu_fetch_pkg::*;
#(
  parameter int LIMIT = IFU_TIMEOUT
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMEOUT_W'(1);
    end
  end

  // Fires on the LIMIT-th enabled cycle, i.e. the cycle in which the count reaches LIMIT.
  assign expired = enable && (count == TIMEOUT_W'(LIMIT - 1));

endmodule

// File: rtl/ysyx_23060124_ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one AR/R read per instruction and
// holds the result for decode until it is accepted and the next PC arrives.
module ysyx_23060124_ifu_fetch
  import ysyx_23060124_ifu_fetch_pkg::*;
#(
  parameter int                  ISA_WIDTH       = IFU_ISA_WIDTH,
  parameter logic [ISA_WIDTH-1:0] RESET_PC       = IFU_RESET_PC,
  parameter int                  TIMEOUT         = IFU_TIMEOUT,
  parameter bit                  CHECK_PC_UPDATE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pc_update,
  input  logic [ISA_WIDTH-1:0] i_pc_next,
  output logic [ISA_WIDTH-1:0] o_araddr,
  output logic                 o_arvalid,
  input  logic                 i_arready,
  input  logic [ISA_WIDTH-1:0] i_rdata,
  input  logic [1:0]           i_rresp,
  input  logic                 i_rvalid,
  output logic                 o_rready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ISA_WIDTH-1:0] o_ins,
  output logic [ISA_WIDTH-1:0] o_pc,
  output logic                 o_fetch_err,
  output logic [31:0]          o_fetch_cnt
);

  fetch_state_e         state;
  logic [ISA_WIDTH-1:0] pc;
  logic                 in_wait;
  logic                 timer_clear;
  logic                 timed_out;

  assign in_wait     = (state == ST_WAIT);
  assign timer_clear = rst || !in_wait;

  ysyx_23060124_ifu_timeout #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .clear  (timer_clear),
    .enable (in_wait),
    .expired(timed_out)
  );

  // Handshake strobes are decoded from the state register; gating with rst keeps
  // them low during reset yet lets AR rise in the very first cycle after release.
  assign o_araddr  = pc;
  assign o_arvalid = !rst && (state == ST_REQ);
  assign o_rready  = !rst && in_wait;
  assign o_valid   = !rst && (state == ST_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      o_ins       <= '0;
      o_pc        <= '0;
      o_fetch_err <= 1'b0;
      o_fetch_cnt <= '0;
    end else begin
      case (state)
        ST_REQ: begin
          if (i_arready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A response in the final permitted cycle still beats the timeout.
          if (i_rvalid) begin
            o_ins       <= i_rdata;
            o_pc        <= pc;
            o_fetch_err <= is_bus_error(i_rresp);
            state       <= ST_HOLD;
          end else if (timed_out) begin
            o_ins       <= ISA_WIDTH'(NOP_INS);
            o_pc        <= pc;
            o_fetch_err <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            o_fetch_cnt <= o_fetch_cnt + 32'd1;
            state       <= ST_WAIT_PC;
          end
        end
        ST_WAIT_PC: begin
          if (i_pc_update) begin
            pc    <= i_pc_next;
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  // A PC update outside WAIT_PC is dropped by the FSM and signals an upstream bug.
  pc_update_only_in_wait_pc: assert property (
    @(posedge clk) disable iff (rst || !CHECK_PC_UPDATE)
    i_pc_update |-> (state == ST_WAIT_PC)
  ) else $error("i_pc_update asserted outside WAIT_PC");

endmodule

// File: tb/tb_ysyx_23060124_ifu_fetch.sv
// Self-checking bench for the fetch stage against a transaction-level model of PC,
// fetched word, error flag and handed-off instruction count.
module tb_ysyx_23060124_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        i_pc_update;
  logic [31:0] i_pc_next;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready;
  logic [31:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid;
  logic        o_rready;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_ins;
  logic [31:0] o_pc;
  logic        o_fetch_err;
  logic [31:0] o_fetch_cnt;

  int          vectors;
  int          miscompares;
  int          ar_hs_total;
  logic [31:0] model_pc;
  logic [31:0] model_cnt;

  // The HOLD-stall scenario injects an illegal PC update on purpose.
  ysyx_23060124_ifu_fetch #(
    .ISA_WIDTH(32), .RESET_PC(RESET_PC), .TIMEOUT(255), .CHECK_PC_UPDATE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .i_pc_update(i_pc_update), .i_pc_next(i_pc_next),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_valid(o_valid), .i_ready(i_ready), .o_ins(o_ins), .o_pc(o_pc),
    .o_fetch_err(o_fetch_err), .o_fetch_cnt(o_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && o_arvalid && i_arready) ar_hs_total++;
  end

  // Drives one complete fetch transaction; reports what decode saw and whether the
  // handshake sequence (latencies, stability, idle WAIT_PC, restart) looked right.
  task automatic fetch_one(input int ar_wait, input int r_wait, input int rdy_wait,
                           input logic [1:0] resp, input logic [31:0] data,
                           input logic [31:0] next_pc, input bit upd_in_hold,
                           output logic [31:0] addr, output logic [31:0] ins,
                           output logic [31:0] pc, output logic err, output bit seq_ok);
    seq_ok = o_arvalid;
    addr   = o_araddr;
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk);
      if (!o_arvalid || o_araddr !== addr) seq_ok = 1'b0;
    end
    i_arready = 1'b1;
    @(negedge clk);
    i_arready = 1'b0;
    if (!o_rready || o_arvalid || o_valid) seq_ok = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      @(negedge clk);
      if (!o_rready || o_valid) seq_ok = 1'b0;
    end
    i_rvalid = 1'b1; i_rdata = data; i_rresp = resp;
    @(negedge clk);
    i_rvalid = 1'b0; i_rdata = $urandom; i_rresp = 2'b00;
    if (!o_valid || o_rready) seq_ok = 1'b0;
    ins = o_ins; pc = o_pc; err = o_fetch_err;
    for (int i = 0; i < rdy_wait; i++) begin
      if (upd_in_hold && i == 0) begin i_pc_update = 1'b1; i_pc_next = next_pc; end
      @(negedge clk);
      i_pc_update = 1'b0;
      if (!o_valid || o_ins !== ins || o_pc !== pc || o_fetch_err !== err) seq_ok = 1'b0;
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    if (o_valid || o_arvalid || o_rready) seq_ok = 1'b0;
    i_pc_update = 1'b1; i_pc_next = next_pc;
    @(negedge clk);
    i_pc_update = 1'b0;
    if (!o_arvalid || o_araddr !== next_pc) seq_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 7;
    if (o_arvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_arvalid: got %b want 0", o_arvalid); end
    if (o_rready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rready: got %b want 0", o_rready); end
    if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b want 0", o_valid); end
    if (o_ins !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_ins: got %h want 0", o_ins); end
    if (o_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_pc: got %h want 0", o_pc); end
    if (o_fetch_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_err: got %b want 0", o_fetch_err); end
    if (o_fetch_cnt !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_cnt: got %h want 0", o_fetch_cnt); end
    rst = 1'b0;
    model_pc = RESET_PC; model_cnt = 32'h0;
    @(negedge clk);
    vectors += 2;
    if (o_arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL first_arvalid: got %b want 1", o_arvalid); end
    if (o_araddr !== RESET_PC) begin miscompares++; $display("[TB] FAIL first_araddr: got %h want %h", o_araddr, RESET_PC); end
  endtask

  task automatic test_basic();
    logic [31:0] addr, ins, pc; logic err; bit ok; logic [31:0] nxt;
    nxt = model_pc + 32'd4;
    fetch_one(0, 0, 0, 2'b00, 32'h0010_0073, nxt, 1'b0, addr, ins, pc, err, ok);
    model_cnt++;
    vectors += 6;
    if (addr !== model_pc) begin miscompares++; $display("[TB] FAIL basic_addr: got %h want %h", addr, model_pc); end
    if (ins !== 32'h0010_0073) begin miscompares++; $display("[TB] FAIL basic_ins: got %h want 00100073", ins); end
    if (pc !== model_pc) begin miscompares++; $display("[TB] FAIL basic_pc: got %h want %h", pc, model_pc); end
    if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_err: got %b want 0", err); end
    if (o_fetch_cnt !== model_cnt) begin miscompares++; $display("[TB] FAIL basic_cnt: got %0d want %0d", o_fetch_cnt, model_cnt); end
    if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_seq: got %b want 1", ok); end
    model_pc = nxt;
  endtask

  task automatic test_ar_stall();
    logic [31:0] addr, ins, pc; logic err; bit ok; int hs0; logic [31:0] data, nxt;
    hs0 = ar_hs_total; data = $urandom; nxt = model_pc + 32'd4;
    fetch_one(3, 0, 0, 2'b00, data, nxt, 1'b0, addr, ins, pc, err, ok);
    model_cnt++;
    vectors += 4;
    if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL arstall_stable: got %b want 1", ok); end
    if (ar_hs_total - hs0 != 1) begin miscompares++; $display("[TB] FAIL arstall_handshakes: got %0d want 1", ar_hs_total - hs0); end
    if (addr !== model_pc) begin miscompares++; $display("[TB] FAIL arstall_addr: got %h want %h", addr, model_pc); end
    if (ins !== data) begin miscompares++; $display("[TB] FAIL arstall_ins: got %h want %h", ins, data); end
    model_pc = nxt;
  endtask

  task automatic test_hold_stall();
    logic [31:0] addr, ins, pc; logic err; bit ok; logic [31:0] data;
    data = $urandom;
    fetch_one(0, 1, 5, 2'b00, data, 32'h8000_0004, 1'b1, addr, ins, pc, err, ok);
    model_cnt++;
    vectors += 4;
    if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_stable: got %b want 1", ok); end
    if (ins !== data) begin miscompares++; $display("[TB] FAIL hold_ins: got %h want %h", ins, data); end
    if (pc !== model_pc) begin miscompares++; $display("[TB] FAIL hold_pc: got %h want %h", pc, model_pc); end
    if (o_fetch_cnt !== model_cnt) begin miscompares++; $display("[TB] FAIL hold_cnt: got %0d want %0d", o_fetch_cnt, model_cnt); end
    model_pc = 32'h8000_0004;
  endtask

  task automatic test_bus_error();
    logic [31:0] addr, ins, pc; logic err; bit ok; logic [31:0] nxt;
    nxt = model_pc + 32'd4;
    fetch_one(1, 2, 1, 2'b10, 32'hDEAD_BEEF, nxt, 1'b0, addr, ins, pc, err, ok);
    model_cnt++;
    vectors += 4;
    if (addr !== model_pc) begin miscompares++; $display("[TB] FAIL buserr_addr: got %h want %h", addr, model_pc); end
    if (ins !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL buserr_ins: got %h want deadbeef", ins); end
    if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL buserr_err: got %b want 1", err); end
    if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL buserr_seq: got %b want 1", ok); end
    model_pc = nxt;
  endtask

  // Memory never answers: the fetch must give up after 255 WAIT cycles and then
  // ignore a response arriving at cycle 260.
  task automatic test_timeout();
    int n; bit seen; logic [31:0] nxt;
    i_arready = 1'b1;
    @(negedge clk);
    i_arready = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (o_valid) seen = 1'b1;
    end
    vectors += 4;
    if (n != 255) begin miscompares++; $display("[TB] FAIL timeout_cycles: got %0d want 255", n); end
    if (o_ins !== NOP) begin miscompares++; $display("[TB] FAIL timeout_ins: got %h want %h", o_ins, NOP); end
    if (o_fetch_err !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_err: got %b want 1", o_fetch_err); end
    if (o_pc !== model_pc) begin miscompares++; $display("[TB] FAIL timeout_pc: got %h want %h", o_pc, model_pc); end
    while (n < 259) begin @(negedge clk); n++; end
    i_rvalid = 1'b1; i_rdata = 32'h1234_5678; i_rresp = 2'b00;
    @(negedge clk);
    i_rvalid = 1'b0;
    vectors += 2;
    if (o_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL late_valid: got %b want 1", o_valid); end
    if (o_ins !== NOP || o_fetch_err !== 1'b1) begin miscompares++; $display("[TB] FAIL late_ignored: got ins %h err %b want %h 1", o_ins, o_fetch_err, NOP); end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    model_cnt++;
    nxt = $urandom & 32'hFFFF_FFFC;
    i_pc_update = 1'b1; i_pc_next = nxt;
    @(negedge clk);
    i_pc_update = 1'b0;
    model_pc = nxt;
    vectors += 2;
    if (o_fetch_cnt !== model_cnt) begin miscompares++; $display("[TB] FAIL timeout_cnt: got %0d want %0d", o_fetch_cnt, model_cnt); end
    if (o_araddr !== model_pc || o_arvalid !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_next: got %h/%b want %h/1", o_araddr, o_arvalid, model_pc); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] addr, ins, pc; logic err; bit ok; logic [31:0] data;
    i_arready = 1'b1;
    @(negedge clk);
    i_arready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors += 4;
    if (o_arvalid | o_rready | o_valid | o_fetch_err) begin miscompares++; $display("[TB] FAIL midrst_strobes: got %b%b%b%b want 0000", o_arvalid, o_rready, o_valid, o_fetch_err); end
    if (o_ins !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_ins: got %h want 0", o_ins); end
    if (o_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_pc: got %h want 0", o_pc); end
    if (o_fetch_cnt !== 32'h0) begin miscompares++; $display("[TB] FAIL midrst_cnt: got %0d want 0", o_fetch_cnt); end
    rst = 1'b0;
    model_pc = RESET_PC; model_cnt = 32'h0;
    @(negedge clk);
    vectors += 1;
    if (o_arvalid !== 1'b1 || o_araddr !== RESET_PC) begin miscompares++; $display("[TB] FAIL midrst_restart: got %b/%h want 1/%h", o_arvalid, o_araddr, RESET_PC); end
    data = $urandom;
    fetch_one(0, 0, 0, 2'b00, data, RESET_PC + 32'd8, 1'b0, addr, ins, pc, err, ok);
    model_cnt++;
    vectors += 2;
    if (addr !== RESET_PC || ins !== data) begin miscompares++; $display("[TB] FAIL midrst_fetch: got %h/%h want %h/%h", addr, ins, RESET_PC, data); end
    if (o_fetch_cnt !== model_cnt) begin miscompares++; $display("[TB] FAIL midrst_cnt_after: got %0d want %0d", o_fetch_cnt, model_cnt); end
    model_pc = RESET_PC + 32'd8;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr, ins, pc, data, nxt; logic err; bit ok; logic [1:0] resp;
    for (int k = 0; k < 16; k++) begin
      data = $urandom;
      nxt  = $urandom & 32'hFFFF_FFFC;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                resp, data, nxt, 1'b0, addr, ins, pc, err, ok);
      model_cnt++;
      vectors++;
      if (addr !== model_pc || ins !== data || pc !== model_pc || err !== (resp != 2'b00) ||
          o_fetch_cnt !== model_cnt || ok !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_%0d: got addr %h ins %h pc %h err %b cnt %0d seq %b want %h %h %h %b %0d 1",
                 k, addr, ins, pc, err, o_fetch_cnt, ok, model_pc, data, model_pc, resp != 2'b00, model_cnt);
      end
      model_pc = nxt;
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; ar_hs_total = 0;
    model_pc = RESET_PC; model_cnt = 32'h0;
    rst = 1'b1; i_pc_update = 1'b0; i_pc_next = 32'h0; i_arready = 1'b0;
    i_rdata = 32'h0; i_rresp = 2'b00; i_rvalid = 1'b0; i_ready = 1'b0;
    test_reset();
    test_basic();
    test_ar_stall();
    test_hold_stall();
    test_bus_error();
    test_timeout();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion want finish");
    $fatal(1, "[TB] run did not complete");
  end

endmodule
